// File: rtl/minesweeper_game_fsm.sv
// Top-level minesweeper game sequencer. It handles level progression, the board-clear and mine-generation handshakes
// (with a watchdog on generation), pause, and an optional per-game time limit.
module minesweeper_game_fsm #(
  parameter int NUM_LEVELS  = 3,
  parameter int LVL_W       = 2,
  parameter int TIME_W      = 10,
  parameter int TIME_LIMIT  = 999,
  parameter int GEN_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic              go,
  input  logic              pause_btn,
  input  logic              is_win,
  input  logic              is_loss,
  input  logic              clear_done,
  input  logic              gen_done,
  input  logic              sec_tick,
  output logic              clear_en,
  output logic              gen_start,
  output logic              enable_vga,
  output logic              clock_run,
  output logic              playing,
  output logic              compare_high_score,
  output logic [LVL_W-1:0]  level,
  output logic [TIME_W-1:0] elapsed,
  output logic              timed_out,
  output logic              gen_error,
  output logic [2:0]        state_out
);

  localparam int WD_W = (GEN_TIMEOUT > 1) ? $clog2(GEN_TIMEOUT) : 1;
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(GEN_TIMEOUT - 1);
  localparam logic [LVL_W-1:0]  LVL_LAST  = LVL_W'(NUM_LEVELS - 1);
  localparam logic [TIME_W-1:0] T_MAX     = '1;
  localparam logic [TIME_W-1:0] T_LIMIT   = TIME_W'(TIME_LIMIT);
  localparam bit                HAS_LIMIT = (TIME_LIMIT != 0);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    GENERATE  = 3'd2,
    IN_GAME   = 3'd3,
    PAUSED    = 3'd4,
    ROUND_WIN = 3'd5,
    WIN       = 3'd6,
    LOSE      = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic              entered_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [TIME_W-1:0] elapsed_q, elapsed_d;
  logic              timed_out_q, timed_out_d;
  logic              gen_error_q, gen_error_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              clear_game;

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= IDLE;
      entered_q   <= 1'b0;
      level_q     <= '0;
      elapsed_q   <= '0;
      timed_out_q <= 1'b0;
      gen_error_q <= 1'b0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      entered_q   <= (state_d != state_q);
      level_q     <= level_d;
      elapsed_q   <= elapsed_d;
      timed_out_q <= timed_out_d;
      gen_error_q <= gen_error_d;
      wd_q        <= wd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    elapsed_d   = elapsed_q;
    timed_out_d = timed_out_q;
    gen_error_d = gen_error_q;
    wd_d        = '0;
    clear_game  = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d    = CLEAR;
          clear_game = 1'b1;
        end
      end
      CLEAR: begin
        if (clear_done) state_d = GENERATE;
      end
      GENERATE: begin
        if (gen_done) begin
          state_d = IN_GAME;
        end else if (wd_q == WD_LAST) begin
          state_d     = IDLE;
          gen_error_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      IN_GAME: begin
        if (sec_tick && (elapsed_q != T_MAX)) elapsed_d = elapsed_q + 1'b1;
        // The limit is checked on the registered count, so the landing tick is shown for one cycle first.
        if (is_loss) begin
          state_d = LOSE;
        end else if (is_win) begin
          state_d = (level_q == LVL_LAST) ? WIN : ROUND_WIN;
        end else if (HAS_LIMIT && (elapsed_q == T_LIMIT)) begin
          state_d     = LOSE;
          timed_out_d = 1'b1;
        end else if (pause_btn) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (pause_btn) state_d = IN_GAME;
      end
      ROUND_WIN: begin
        level_d = level_q + 1'b1;
        state_d = CLEAR;
      end
      WIN, LOSE: begin
        if (go) begin
          state_d    = CLEAR;
          clear_game = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_game) begin
      level_d     = '0;
      elapsed_d   = '0;
      timed_out_d = 1'b0;
      gen_error_d = 1'b0;
    end
  end

  always_comb begin
    clear_en           = 1'b0;
    gen_start          = 1'b0;
    enable_vga         = 1'b1;
    clock_run          = 1'b0;
    playing            = 1'b0;
    compare_high_score = 1'b0;
    case (state_q)
      CLEAR: begin
        clear_en   = 1'b1;
        enable_vga = 1'b0;
      end
      GENERATE: gen_start = entered_q;
      IN_GAME: begin
        playing   = 1'b1;
        clock_run = 1'b1;
      end
      WIN:     compare_high_score = entered_q;
      default: ;
    endcase
  end

  assign level     = level_q;
  assign elapsed   = elapsed_q;
  assign timed_out = timed_out_q;
  assign gen_error = gen_error_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_minesweeper_game_fsm.sv
// Scoreboard bench for minesweeper_game_fsm: a game-rule reference model queues the expected outputs for every cycle,
// and a separate monitor pops and compares them.
module tb_minesweeper_game_fsm;

  localparam int NUM_LEVELS  = 3;
  localparam int LVL_W       = 2;
  localparam int TIME_W      = 4;
  localparam int TIME_LIMIT  = 5;
  localparam int GEN_TIMEOUT = 16;

  typedef struct packed {
    logic [2:0]        st;
    logic [LVL_W-1:0]  lvl;
    logic [TIME_W-1:0] el;
    logic [7:0]        flags;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_in = 1'b1;
  logic              go = 1'b0, pause_btn = 1'b0, is_win = 1'b0, is_loss = 1'b0;
  logic              clear_done = 1'b0, gen_done = 1'b0, sec_tick = 1'b0;
  logic              clear_en, gen_start, enable_vga, clock_run, playing, compare_high_score;
  logic [LVL_W-1:0]  level;
  logic [TIME_W-1:0] elapsed;
  logic              timed_out, gen_error;
  logic [2:0]        state_out;

  int   checkCount = 0;
  int   passCount  = 0;
  int   cycleNum   = 0;
  exp_t expQ[$];

  int mState = 0, mLevel = 0, mElapsed = 0, mTimedOut = 0, mGenErr = 0, mGenCycles = 0;
  bit mJustEntered = 1'b0;

  minesweeper_game_fsm #(
    .NUM_LEVELS(NUM_LEVELS), .LVL_W(LVL_W), .TIME_W(TIME_W),
    .TIME_LIMIT(TIME_LIMIT), .GEN_TIMEOUT(GEN_TIMEOUT)
  ) dut (
    .clk(clk), .reset_in(reset_in), .go(go), .pause_btn(pause_btn),
    .is_win(is_win), .is_loss(is_loss), .clear_done(clear_done),
    .gen_done(gen_done), .sec_tick(sec_tick), .clear_en(clear_en),
    .gen_start(gen_start), .enable_vga(enable_vga), .clock_run(clock_run),
    .playing(playing), .compare_high_score(compare_high_score),
    .level(level), .elapsed(elapsed), .timed_out(timed_out),
    .gen_error(gen_error), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expd);
    checkCount++;
    if (act === expd) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expd);
  endtask

  function automatic exp_t modelOutputs();
    exp_t e;
    e.st  = 3'(mState);
    e.lvl = LVL_W'(mLevel);
    e.el  = TIME_W'(mElapsed);
    e.flags = {mTimedOut[0], mGenErr[0], (mState == 1), (mState == 2 && mJustEntered),
               (mState != 1), (mState == 3), (mState == 3), (mState == 6 && mJustEntered)};
    return e;
  endfunction

  // Game rules: 0 idle, 1 clear, 2 generate, 3 playing, 4 paused, 5 round won, 6 won, 7 lost.
  task automatic modelStep(input bit rst, input bit g, input bit pb, input bit w, input bit l,
                           input bit cd, input bit gd, input bit tk);
    int nxt;
    bit newGame;
    if (rst) begin
      mState = 0; mLevel = 0; mElapsed = 0; mTimedOut = 0; mGenErr = 0;
      mGenCycles = 0; mJustEntered = 1'b0;
      return;
    end
    nxt = mState;
    newGame = 1'b0;
    case (mState)
      0: if (g) begin nxt = 1; newGame = 1'b1; end
      1: if (cd) nxt = 2;
      2: begin
        if (gd) nxt = 3;
        else if (mGenCycles == GEN_TIMEOUT - 1) begin nxt = 0; mGenErr = 1; end
      end
      3: begin
        if (l) nxt = 7;
        else if (w) nxt = (mLevel == NUM_LEVELS - 1) ? 6 : 5;
        else if (TIME_LIMIT != 0 && mElapsed == TIME_LIMIT) begin nxt = 7; mTimedOut = 1; end
        else if (pb) nxt = 4;
        if (tk && mElapsed < (1 << TIME_W) - 1) mElapsed = mElapsed + 1;
      end
      4: if (pb) nxt = 3;
      5: begin mLevel = mLevel + 1; nxt = 1; end
      default: if (g) begin nxt = 1; newGame = 1'b1; end
    endcase
    if (newGame) begin
      mLevel = 0; mElapsed = 0; mTimedOut = 0; mGenErr = 0;
    end
    mGenCycles   = (mState == 2 && nxt == 2) ? mGenCycles + 1 : 0;
    mJustEntered = (nxt != mState);
    mState       = nxt;
  endtask

  task automatic applyStimulus(input bit rst, input bit g, input bit pb, input bit w, input bit l,
                               input bit cd, input bit gd, input bit tk);
    exp_t e;
    @(posedge clk);
    #2;
    reset_in = rst; go = g; pause_btn = pb; is_win = w; is_loss = l;
    clear_done = cd; gen_done = gd; sec_tick = tk;
    modelStep(rst, g, pb, w, l, cd, gd, tk);
    e = modelOutputs();
    expQ.push_back(e);
    if (rst) begin
      #1;
      checkOutput("async reset state", 32'(state_out), 32'(e.st));
      checkOutput("async reset flags",
                  32'({timed_out, gen_error, clear_en, gen_start, enable_vga, clock_run, playing, compare_high_score}),
                  32'(e.flags));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic startRound();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  // Monitor: one queued expectation per clock, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycleNum++;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput($sformatf("state c%0d", cycleNum), 32'(state_out), 32'(e.st));
        checkOutput($sformatf("level c%0d", cycleNum), 32'(level), 32'(e.lvl));
        checkOutput($sformatf("elapsed c%0d", cycleNum), 32'(elapsed), 32'(e.el));
        checkOutput($sformatf("flags c%0d", cycleNum),
                    32'({timed_out, gen_error, clear_en, gen_start, enable_vga, clock_run, playing, compare_high_score}),
                    32'(e.flags));
      end
    end
  end

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    idle(1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    idle(4);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    for (int lv = 0; lv < NUM_LEVELS; lv++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
      idle(1);
      if (lv < NUM_LEVELS - 1) startRound();
    end
    idle(2);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    startRound();
    for (int i = 0; i < TIME_LIMIT; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    startRound();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    idle(2);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    idle(20);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    idle(GEN_TIMEOUT - 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    idle(1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    idle(3);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 20,
                    $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 5,
                    $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 30,
                    $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 25);
    end
    idle(1);
    @(posedge clk);
    #3;
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/minesweeper_game_fsm.md
Name: minesweeper_game_fsm

Overview:
Parametrised top-level game sequencer for the minesweeper design. Sits between the button/debounce logic and the board datapath (board clear, mine generator, VGA renderer, game timer, high-score unit). Extends the single-round control with multi-level progression, handshaked board clear and mine generation with a watchdog, pause, and an optional round time limit.

Parameters:
NUM_LEVELS, 3, levels per game; the final level win ends the game (must be >=1)
LVL_W, 2, width of level output (must satisfy 2^LVL_W >= NUM_LEVELS)
TIME_W, 10, width of elapsed-seconds counter
TIME_LIMIT, 999, seconds allowed per game; 0 = no limit (must be < 2^TIME_W)
GEN_TIMEOUT, 4096, clk cycles allowed for gen_done after gen_start

Ports:
clk  in  1  system clock
reset_in  in  1  asynchronous, active-high reset
go  in  1  start/restart request, 1-cycle pulse
pause_btn  in  1  pause toggle, 1-cycle pulse
is_win  in  1  board reports all safe cells revealed
is_loss  in  1  board reports mine revealed
clear_done  in  1  board clear finished
gen_done  in  1  mine generation finished
sec_tick  in  1  1 Hz strobe, 1 clk wide
clear_en  out  1  board clear request (level)
gen_start  out  1  mine generation start, 1-cycle pulse
enable_vga  out  1  renderer enable
clock_run  out  1  game timer running
playing  out  1  board accepts player input
compare_high_score  out  1  1-cycle pulse on game win
level  out  LVL_W  current level, 0-based
elapsed  out  TIME_W  seconds played this game
timed_out  out  1  game lost by time limit (sticky)
gen_error  out  1  generation watchdog fired (sticky)
state_out  out  3  current state encoding (debug)

Behaviour:
- Registered Moore FSM with 3-bit state: IDLE=0, CLEAR=1, GENERATE=2, IN_GAME=3, PAUSED=4, ROUND_WIN=5, WIN=6, LOSE=7. Undefined encodings go to IDLE.
- Async reset (reset_in=1): state=IDLE, level=0, elapsed=0, timed_out=0, gen_error=0, watchdog=0. All pulse/level outputs are 0 except enable_vga=1.
- IDLE: go -> CLEAR. On this transition clear level, elapsed, timed_out and gen_error.
- CLEAR: clear_en=1, enable_vga=0. clear_done -> GENERATE.
- GENERATE: gen_start=1 only in the first cycle of the state. Watchdog counts from 0 each cycle. gen_done -> IN_GAME. If the watchdog reaches GEN_TIMEOUT-1 without gen_done -> IDLE with gen_error=1. gen_done in the timeout cycle wins.
- IN_GAME: playing=1, clock_run=1. On sec_tick, elapsed increments and saturates at 2^TIME_W-1. Transition priority, highest first:
  1. is_loss -> LOSE.
  2. is_win -> WIN if level==NUM_LEVELS-1, else ROUND_WIN.
  3. TIME_LIMIT!=0 and elapsed==TIME_LIMIT -> LOSE with timed_out=1.
  4. pause_btn -> PAUSED.
  The tick that lands on TIME_LIMIT is counted first; the transition happens on the next cycle.
- PAUSED: playing=0, clock_run=0, enable_vga=1. elapsed is frozen. is_win, is_loss, go and sec_tick are ignored. pause_btn -> IN_GAME.
- ROUND_WIN: lasts 1 cycle; level <= level+1, then -> CLEAR. elapsed is kept, so time accumulates across levels.
- WIN: compare_high_score=1 in the first cycle only. go -> CLEAR with the same clears as from IDLE.
- LOSE: go -> CLEAR with the same clears as from IDLE.
- go is ignored in CLEAR, GENERATE, IN_GAME, PAUSED and ROUND_WIN.
- When not stated otherwise, enable_vga=1.
- Reset asserted mid-operation returns to IDLE immediately, mid-generation included. No gen_start pulse occurs on reset exit.
- Outputs are decoded from registered state plus a one-cycle "state entered" flag; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset, go pulse, clear_done 2 cycles later, gen_done 5 cycles after gen_start -> states 0,1,2,3; gen_start high exactly 1 cycle; playing=1.
2. NUM_LEVELS=3: is_win pulsed in IN_GAME three times, each followed by the clear/gen handshake -> level 0->1->2; third win enters WIN; compare_high_score high 1 cycle; elapsed not cleared between levels.
3. TIME_LIMIT=5, 5 sec_ticks in IN_GAME -> elapsed=5, next cycle LOSE, timed_out=1. Then go -> elapsed=0, timed_out=0, state CLEAR.
4. pause_btn in IN_GAME, then 3 sec_ticks and is_loss while paused, then pause_btn -> elapsed unchanged, still IN_GAME after unpause, clock_run=0 while paused.
5. GEN_TIMEOUT=16, gen_done never asserted -> IDLE after 16 cycles in GENERATE, gen_error=1. Repeat with gen_done in cycle 16 -> IN_GAME, gen_error=0.
6. is_win and is_loss in the same cycle -> LOSE. reset_in asserted mid-GENERATE -> IDLE asynchronously, level=0, all outputs at reset values.
